rsc_term_ctrl: RTL and testbench

Frame controller and trellis terminator that sits directly upstream of the 3-register recursive systematic convolutional encoder. It buffers incoming information bits into ping-pong frame banks of K bits. Each full frame is streamed to the encoder one bit per clock, because the encoder has no enable and shifts every cycle. The block then appends 3 tail bits computed from the encoder state, so the encoder returns to state 000 before the next frame.

---
 rtl/rsc_term_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rsc_term_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsc_term_ctrl.sv
// Frame buffer and trellis terminator feeding a 3-register RSC encoder.
// Ping-pong banks of K bits are streamed out, then 3 tail bits return the encoder to 000.
module rsc_term_ctrl #(
   parameter int unsigned K = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_bit,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [2:0] enc_state,
   output logic       enc_in,
   output logic       sys_out,
   output logic       out_valid,
   output logic       tail,
   output logic       sof,
   output logic       eof
);

   localparam int unsigned PW = (K > 1) ? $clog2(K) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(K - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_TAIL
   } state_t;

   state_t            state_q, state_d;
   logic [1:0][K-1:0] bank_q, bank_d;
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [PW-1:0]     rptr_nxt;
   logic              wbank_q, wbank_d;
   logic              rbank_q, rbank_d;
   logic [1:0]        full_q, full_d;
   logic              s_ready_q, s_ready_d;
   logic [1:0]        tcnt_q, tcnt_d;
   logic              data_q, data_d;
   logic              accept;
   logic              release_bank;
   logic              unused_w2;

   // Write side: fill the current bank, mark it full on its last bit
   always_comb begin
      bank_d    = bank_q;
      wptr_d    = wptr_q;
      wbank_d   = wbank_q;
      full_d    = full_q;
      accept    = s_valid & s_ready_q;

      if (release_bank) begin
         full_d[rbank_q] = 1'b0;
      end

      if (accept) begin
         bank_d[wbank_q][wptr_q] = s_bit;
         if (wptr_q == PTR_LAST) begin
            full_d[wbank_q] = 1'b1;
            wptr_d          = '0;
            wbank_d         = ~wbank_q;
         end else begin
            wptr_d = wptr_q + 1'b1;
         end
      end

      // Look ahead at the bank the next accepted bit would land in
      s_ready_d = ~full_d[wbank_d];
   end

   // Read FSM: data_q is preloaded one edge ahead so DATA cycles drive a flop
   always_comb begin
      state_d      = state_q;
      rptr_d       = rptr_q;
      rbank_d      = rbank_q;
      tcnt_d       = tcnt_q;
      data_d       = data_q;
      release_bank = 1'b0;
      rptr_nxt     = rptr_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            data_d = 1'b0;
            if (full_q[rbank_q]) begin
               state_d = ST_DATA;
               rptr_d  = '0;
               data_d  = bank_q[rbank_q][0];
            end
         end
         ST_DATA: begin
            if (rptr_q == PTR_LAST) begin
               state_d      = ST_TAIL;
               tcnt_d       = 2'd0;
               release_bank = 1'b1;
               rbank_d      = ~rbank_q;
               data_d       = 1'b0;
            end else begin
               rptr_d = rptr_nxt;
               data_d = bank_q[rbank_q][rptr_nxt];
            end
         end
         ST_TAIL: begin
            if (tcnt_q == 2'd2) begin
               // rbank already points at the next bank here
               if (full_q[rbank_q]) begin
                  state_d = ST_DATA;
                  rptr_d  = '0;
                  data_d  = bank_q[rbank_q][0];
               end else begin
                  state_d = ST_IDLE;
                  data_d  = 1'b0;
               end
            end else begin
               tcnt_d = tcnt_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            data_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q    <= '0;
         wptr_q    <= '0;
         wbank_q   <= 1'b0;
         full_q    <= '0;
         s_ready_q <= 1'b0;
         state_q   <= ST_IDLE;
         rptr_q    <= '0;
         rbank_q   <= 1'b0;
         tcnt_q    <= '0;
         data_q    <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         wptr_q    <= wptr_d;
         wbank_q   <= wbank_d;
         full_q    <= full_d;
         s_ready_q <= s_ready_d;
         state_q   <= state_d;
         rptr_q    <= rptr_d;
         rbank_q   <= rbank_d;
         tcnt_q    <= tcnt_d;
         data_q    <= data_d;
      end
   end

   // Tail input cancels the feedback w3^w4, so the newest register receives 0
   always_comb begin
      enc_in    = 1'b0;
      unused_w2 = enc_state[2];
      if (state_q == ST_TAIL) begin
         enc_in = enc_state[1] ^ enc_state[0];
      end else if (state_q == ST_DATA) begin
         enc_in = data_q;
      end
      sys_out   = enc_in;
      out_valid = (state_q == ST_DATA) || (state_q == ST_TAIL);
      tail      = (state_q == ST_TAIL);
      sof       = (state_q == ST_DATA) && (rptr_q == '0);
      eof       = (state_q == ST_TAIL) && (tcnt_q == 2'd2);
      s_ready   = s_ready_q;
   end

endmodule

// File: tb/tb_rsc_term_ctrl.sv
// Directed and random bench for rsc_term_ctrl, with a behavioural RSC encoder per instance.
module tb_rsc_term_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       s_bit8, s_valid8, s_ready8, enc_in8, sys_out8, out_valid8, tail8, sof8, eof8;
   logic [2:0] es8;
   logic       s_bit40, s_valid40, s_ready40, enc_in40, sys_out40, out_valid40, tail40, sof40, eof40;
   logic [2:0] es40;
   logic       par40;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic sys;
      logic par;
      logic tl;
      logic sf;
      logic ef;
   } exp_t;

   exp_t expq[$];

   rsc_term_ctrl #(.K(8)) dut8 (
      .clk(clk), .rst(rst), .s_bit(s_bit8), .s_valid(s_valid8), .s_ready(s_ready8),
      .enc_state(es8), .enc_in(enc_in8), .sys_out(sys_out8), .out_valid(out_valid8),
      .tail(tail8), .sof(sof8), .eof(eof8)
   );

   rsc_term_ctrl #(.K(40)) dut40 (
      .clk(clk), .rst(rst), .s_bit(s_bit40), .s_valid(s_valid40), .s_ready(s_ready40),
      .enc_state(es40), .enc_in(enc_in40), .sys_out(sys_out40), .out_valid(out_valid40),
      .tail(tail40), .sof(sof40), .eof(eof40)
   );

   always #5 clk = ~clk;

   // Encoder: state {w2,w3,w4}, feedback w3^w4, parity a^w2^w4
   always_ff @(posedge clk or posedge rst) begin
      if (rst) es8 <= '0;
      else     es8 <= {enc_in8 ^ es8[1] ^ es8[0], es8[2], es8[1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) es40 <= '0;
      else     es40 <= {enc_in40 ^ es40[1] ^ es40[0], es40[2], es40[1]};
   end

   assign par40 = (enc_in40 ^ es40[1] ^ es40[0]) ^ es40[2] ^ es40[0];

   task automatic test_reset();
      rst = 1'b1;
      s_valid8 = 1'b0; s_bit8 = 1'b0; s_valid40 = 1'b0; s_bit40 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready8, out_valid8, enc_in8, sys_out8, tail8, sof8, eof8} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs8: got %b expected 0000000",
                  {s_ready8, out_valid8, enc_in8, sys_out8, tail8, sof8, eof8});
      end
      checks++;
      if ({s_ready40, out_valid40, enc_in40, sys_out40, tail40, sof40, eof40} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs40: got %b expected 0000000",
                  {s_ready40, out_valid40, enc_in40, sys_out40, tail40, sof40, eof40});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (s_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_low: got %b expected 0", s_ready8);
      end
      @(negedge clk);
      checks++;
      if ({s_ready8, s_ready40} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready_rise: got %b expected 11", {s_ready8, s_ready40});
      end
   endtask

   // One frame into an idle K=8 instance; checks data, tail, sof/eof and final state
   task automatic test_frame(input string tag, input logic [0:7] bits, input logic [0:2] tbits);
      logic [0:10] exp_v;
      logic [5:0]  want;
      exp_v = {bits, tbits};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (s_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL %s ready bit%0d: got %b expected 1", tag, i, s_ready8);
         end
         s_valid8 = 1'b1;
         s_bit8   = bits[i];
      end
      @(negedge clk);
      s_valid8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL %s latency: out_valid got %b expected 0", tag, out_valid8);
      end
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         want = {1'b1, exp_v[j], exp_v[j], j >= 8, j == 0, j == 10};
         checks++;
         if ({out_valid8, sys_out8, enc_in8, tail8, sof8, eof8} !== want) begin
            errors++;
            $display("FAIL %s cycle%0d {ov,sys,enc,tail,sof,eof}: got %b expected %b", tag, j,
                     {out_valid8, sys_out8, enc_in8, tail8, sof8, eof8}, want);
         end
         if (bits == 8'h00) begin
            checks++;
            if (es8 !== 3'b000) begin
               errors++;
               $display("FAIL %s zero_state cycle%0d: got %b expected 000", tag, j, es8);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({out_valid8, es8} !== 4'b0000) begin
         errors++;
         $display("FAIL %s end {ov,state}: got %b expected 0000", tag, {out_valid8, es8});
      end
   endtask

   task automatic test_back_to_back();
      logic [0:15] bits;
      logic [0:21] exp_out;
      logic        ov_exp;
      int          k;
      bits    = {8'b10110011, 8'b11100100};
      exp_out = {8'b10110011, 3'b101, 8'b11100100, 3'b010};
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         checks++;
         if (s_ready8 !== (n != 16)) begin
            errors++;
            $display("FAIL b2b ready n%0d: got %b expected %b", n, s_ready8, n != 16);
         end
         ov_exp = (n >= 9) && (n <= 30);
         checks++;
         if (out_valid8 !== ov_exp) begin
            errors++;
            $display("FAIL b2b out_valid n%0d: got %b expected %b", n, out_valid8, ov_exp);
         end
         if (ov_exp) begin
            k = n - 9;
            checks++;
            if ({sys_out8, tail8, sof8, eof8} !== {exp_out[k], (k % 11) >= 8, (k % 11) == 0, (k % 11) == 10}) begin
               errors++;
               $display("FAIL b2b n%0d {sys,tail,sof,eof}: got %b expected %b", n,
                        {sys_out8, tail8, sof8, eof8},
                        {exp_out[k], (k % 11) >= 8, (k % 11) == 0, (k % 11) == 10});
            end
         end
         if (n == 31) begin
            checks++;
            if (es8 !== 3'b000) begin
               errors++;
               $display("FAIL b2b end_state: got %b expected 000", es8);
            end
         end
         if (n < 16) begin
            s_valid8 = 1'b1;
            s_bit8   = bits[n];
         end else begin
            s_valid8 = 1'b0;
         end
      end
   endtask

   task automatic test_stall();
      logic [0:7] bits;
      int         sent;
      logic       seen;
      bits = 8'b01101001;
      sent = 0;
      for (int n = 0; n < 40 && sent < 8; n++) begin
         @(negedge clk);
         checks++;
         if ({out_valid8, enc_in8, sof8} !== 3'b000) begin
            errors++;
            $display("FAIL stall idle n%0d {ov,enc,sof}: got %b expected 000", n, {out_valid8, enc_in8, sof8});
         end
         if (n == 2 || n == 3 || n == 7 || n == 8) begin
            s_valid8 = 1'b0;
            s_bit8   = 1'b1;
         end else begin
            s_valid8 = 1'b1;
            s_bit8   = bits[sent];
            sent++;
         end
      end
      @(negedge clk);
      s_valid8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL stall latency: out_valid got %b expected 0", out_valid8);
      end
      @(negedge clk);
      checks++;
      if ({out_valid8, sof8, sys_out8} !== {2'b11, bits[0]}) begin
         errors++;
         $display("FAIL stall start {ov,sof,sys}: got %b expected %b", {out_valid8, sof8, sys_out8}, {2'b11, bits[0]});
      end
      seen = 1'b0;
      for (int n = 0; n < 12 && !seen; n++) begin
         @(negedge clk);
         if (eof8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL stall eof_timeout: got %b expected 1", seen);
      end
      @(negedge clk);
      checks++;
      if ({out_valid8, es8} !== 4'b0000) begin
         errors++;
         $display("FAIL stall end {ov,state}: got %b expected 0000", {out_valid8, es8});
      end
   endtask

   task automatic test_mid_reset();
      logic [0:7] bits;
      bits = 8'b10110011;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s_valid8 = 1'b1;
         s_bit8   = bits[i];
      end
      @(negedge clk);
      s_valid8 = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({out_valid8, sys_out8, sof8} !== 3'b110) begin
         errors++;
         $display("FAIL midrst rptr3 {ov,sys,sof}: got %b expected 110", {out_valid8, sys_out8, sof8});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({s_ready8, out_valid8, enc_in8, sys_out8, tail8, sof8, eof8} !== 7'b0) begin
         errors++;
         $display("FAIL midrst async_outputs: got %b expected 0000000",
                  {s_ready8, out_valid8, enc_in8, sys_out8, tail8, sof8, eof8});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (s_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL midrst ready_before_edge: got %b expected 0", s_ready8);
      end
      @(negedge clk);
      checks++;
      if (s_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL midrst ready_after_edge: got %b expected 1", s_ready8);
      end
   endtask

   // K=40 random frames against a reference RSC computed from the accepted bits
   task automatic test_random();
      logic [39:0] fbuf;
      logic [2:0]  st;
      logic        u, a;
      int          fcnt, fed, done, cyc;
      logic        chk_zero;
      exp_t        e;
      fcnt = 0; fed = 0; done = 0; cyc = 0; chk_zero = 1'b0;
      fbuf = '0;
      while (done < 200 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         if (chk_zero) begin
            chk_zero = 1'b0;
            checks++;
            if (es40 !== 3'b000) begin
               errors++;
               $display("FAIL rand post_eof_state frame%0d: got %b expected 000", done, es40);
            end
         end
         checks++;
         if (sys_out40 !== enc_in40) begin
            errors++;
            $display("FAIL rand sys_eq_enc: got %b expected %b", sys_out40, enc_in40);
         end
         if (out_valid40 === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL rand unexpected_output: got out_valid 1 expected 0");
            end else begin
               e = expq.pop_front();
               if ({sys_out40, par40, tail40, sof40, eof40} !== e) begin
                  errors++;
                  $display("FAIL rand frame%0d {sys,par,tail,sof,eof}: got %b expected %b", done,
                           {sys_out40, par40, tail40, sof40, eof40}, e);
               end
               if (e.ef) begin
                  done++;
                  chk_zero = 1'b1;
               end
            end
         end else begin
            checks++;
            if (enc_in40 !== 1'b0) begin
               errors++;
               $display("FAIL rand idle_enc_in: got %b expected 0", enc_in40);
            end
         end
         if (fed < 200) begin
            s_valid40 = ($urandom_range(0, 9) != 0);
            s_bit40   = 1'($urandom);
         end else begin
            s_valid40 = 1'b0;
         end
         if (s_valid40 && s_ready40) begin
            fbuf[fcnt] = s_bit40;
            fcnt++;
            if (fcnt == 40) begin
               fcnt = 0;
               fed++;
               st = 3'b000;
               for (int i = 0; i < 40; i++) begin
                  u = fbuf[i];
                  a = u ^ st[1] ^ st[0];
                  expq.push_back('{sys: u, par: a ^ st[2] ^ st[0], tl: 1'b0, sf: (i == 0), ef: 1'b0});
                  st = {a, st[2], st[1]};
               end
               for (int t = 0; t < 3; t++) begin
                  u = st[1] ^ st[0];
                  expq.push_back('{sys: u, par: st[2] ^ st[0], tl: 1'b1, sf: 1'b0, ef: (t == 2)});
                  st = {1'b0, st[2], st[1]};
               end
            end
         end
      end
      checks++;
      if (done != 200) begin
         errors++;
         $display("FAIL rand frame_count: got %0d expected 200", done);
      end
      @(negedge clk);
      checks++;
      if ({out_valid40, es40} !== 4'b0000) begin
         errors++;
         $display("FAIL rand final {ov,state}: got %b expected 0000", {out_valid40, es40});
      end
   endtask

   initial begin
      test_reset();
      test_frame("single", 8'b10110011, 3'b101);
      test_frame("all_zero", 8'b00000000, 3'b000);
      test_back_to_back();
      test_stall();
      test_mid_reset();
      test_frame("after_reset", 8'b10110011, 3'b101);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
